// File: rtl/muldiv.sv
// Iterative multiply/divide unit holding the HI/LO registers; 32 or 64 steps of one bit each.
// Build option MULDIV_FASTMUL_EN: single-cycle multiply via '*', divide stays iterative.
module muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic        sgn,
   input  logic        dword,
   input  logic [63:0] rs,
   input  logic [63:0] rt,
   input  logic        flush,
   input  logic        wrhi,
   input  logic        wrlo,
   input  logic [63:0] wrdata,
   output logic [63:0] hi,
   output logic [63:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t       r_state, w_next;
   logic         r_op, r_dword, r_neg_q, r_neg_r;
   logic [5:0]   r_cnt;
   logic [127:0] r_acc;
   logic [63:0]  r_x, r_y;
   logic [63:0]  r_hi, r_lo;
   logic         r_busy, r_done;

   logic         w_load, w_step, w_commit, w_last, w_cnt_last, w_align;
   logic [63:0]  w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_x_src, w_x_init, w_y_init;
   logic         w_a_neg, w_b_neg;
   logic [64:0]  w_rem_sh;
   logic [63:0]  w_rem_sub, w_rem_next;
   logic         w_qbit;
   logic [127:0] w_p;
   logic [63:0]  w_q, w_r, w_res_hi, w_res_lo;
`ifdef MULDIV_FASTMUL_EN
   logic [127:0] w_fast_prod;
`else
   logic [127:0] w_mul_acc;
`endif

   // Operand magnitudes; word operands are first extended to 64 bits
   always_comb begin
      w_a_ext = dword ? rs : (sgn ? {{32{rs[31]}}, rs[31:0]} : {32'b0, rs[31:0]});
      w_b_ext = dword ? rt : (sgn ? {{32{rt[31]}}, rt[31:0]} : {32'b0, rt[31:0]});
      w_a_neg = sgn & w_a_ext[63];
      w_b_neg = sgn & w_b_ext[63];
      w_a_mag = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
      w_b_mag = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;
`ifdef MULDIV_FASTMUL_EN
      w_align = op;
`else
      w_align = 1'b1;
`endif
      // Shift register is MSB-first, so word operands sit in the top half
      w_x_src  = op ? w_a_mag : w_b_mag;
      w_x_init = (dword || !w_align) ? w_x_src : {w_x_src[31:0], 32'b0};
      w_y_init = op ? w_b_mag : w_a_mag;
   end

   // One iteration: restoring-divide step and MSB-first shift-add
   always_comb begin
      w_rem_sh   = {r_acc[63:0], r_x[63]};
      w_qbit     = (w_rem_sh >= {1'b0, r_y});
      w_rem_sub  = w_rem_sh[63:0] - r_y;
      w_rem_next = w_qbit ? w_rem_sub : w_rem_sh[63:0];
`ifdef MULDIV_FASTMUL_EN
      w_fast_prod = {64'b0, r_x} * {64'b0, r_y};
`else
      w_mul_acc   = {r_acc[126:0], 1'b0} + (r_x[63] ? {64'b0, r_y} : 128'd0);
`endif
      w_cnt_last = (r_cnt == (r_dword ? 6'd63 : 6'd31));
`ifdef MULDIV_FASTMUL_EN
      w_last = !r_op || w_cnt_last;
`else
      w_last = w_cnt_last;
`endif
   end

   // Sign correction and result formatting; divide-by-zero and MININT/-1
   // fall out of the magnitude algorithm without special cases.
   always_comb begin
      w_p = r_neg_q ? (128'd0 - r_acc) : r_acc;
      w_q = r_neg_q ? (64'd0 - r_x) : r_x;
      w_r = r_neg_r ? (64'd0 - r_acc[63:0]) : r_acc[63:0];
      if (!r_op) begin
         if (r_dword) begin
            w_res_hi = w_p[127:64];
            w_res_lo = w_p[63:0];
         end else begin
            w_res_hi = {{32{w_p[63]}}, w_p[63:32]};
            w_res_lo = {{32{w_p[31]}}, w_p[31:0]};
         end
      end else begin
         if (r_dword) begin
            w_res_hi = w_r;
            w_res_lo = w_q;
         end else begin
            w_res_hi = {{32{w_r[31]}}, w_r[31:0]};
            w_res_lo = {{32{w_q[31]}}, w_q[31:0]};
         end
      end
   end

   // Next state: flush beats start; MTHI/MTLO abort only during RUN
   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_commit = 1'b0;
      if (flush) begin
         w_next = S_IDLE;
      end else if (start) begin
         w_next = S_RUN;
         w_load = 1'b1;
      end else begin
         case (r_state)
            S_RUN: begin
               if (wrhi || wrlo) begin
                  w_next = S_IDLE;
               end else begin
                  w_step = 1'b1;
                  if (w_last) w_next = S_FIX;
               end
            end
            S_FIX: begin
               w_commit = 1'b1;
               w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op    <= 1'b0;
         r_dword <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_x     <= '0;
         r_y     <= '0;
      end else if (w_load) begin
         r_op    <= op;
         r_dword <= dword;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_x     <= w_x_init;
         r_y     <= w_y_init;
      end else if (w_step) begin
         r_cnt <= r_cnt + 6'd1;
         if (r_op) begin
            r_acc <= {64'b0, w_rem_next};
            r_x   <= {r_x[62:0], w_qbit};
         end else begin
`ifdef MULDIV_FASTMUL_EN
            r_acc <= w_fast_prod;
`else
            r_acc <= w_mul_acc;
            r_x   <= {r_x[62:0], 1'b0};
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (wrhi)          r_hi <= wrdata;
         else if (w_commit) r_hi <= w_res_hi;
         if (wrlo)          r_lo <= wrdata;
         else if (w_commit) r_lo <= w_res_lo;
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: expected HI/LO/latency queued at issue, checked when done pulses.
module tb_muldiv;
   logic        clk = 1'b0;
   logic        rst, start, op, sgn, dword, flush, wrhi, wrlo;
   logic [63:0] rs, rt, wrdata;
   logic [63:0] hi, lo;
   logic        busy, done;

   always #5 clk = ~clk;

   muldiv dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .dword(dword),
      .rs(rs), .rt(rt), .flush(flush), .wrhi(wrhi), .wrlo(wrlo), .wrdata(wrdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   typedef struct {
      logic [63:0] ehi;
      logic [63:0] elo;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] cur_hi = '0, cur_lo = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic int lat_of(input logic o, input logic d);
`ifdef MULDIV_FASTMUL_EN
      if (!o) return 2;
`endif
      return d ? 65 : 33;
   endfunction

   // Reference arithmetic from SV native signed/unsigned operators
   function automatic void model(input logic o, input logic s, input logic d,
                                 input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] eh, output logic [63:0] el);
      logic signed [127:0] pa, pb, ps;
      logic [127:0]        pu, p;
      logic signed [63:0]  sa, sb2;
      logic [63:0]         ua, ub, q, r;
      if (d) begin
         sa = a; sb2 = b; ua = a; ub = b;
      end else begin
         sa = {{32{a[31]}}, a[31:0]}; sb2 = {{32{b[31]}}, b[31:0]};
         ua = {32'b0, a[31:0]};      ub = {32'b0, b[31:0]};
      end
      if (!o) begin
         pa = sa; pb = sb2;
         ps = pa * pb;
         pu = {64'b0, ua} * {64'b0, ub};
         p  = s ? ps : pu;
         if (d) begin eh = p[127:64]; el = p[63:0]; end
         else begin eh = {{32{p[63]}}, p[63:32]}; el = {{32{p[31]}}, p[31:0]}; end
      end else begin
         if (s) begin q = sa / sb2; r = sa % sb2; end
         else   begin q = ua / ub;  r = ua % ub;  end
         if (d) begin el = q; eh = r; end
         else begin el = {{32{q[31]}}, q[31:0]}; eh = {{32{r[31]}}, r[31:0]}; end
      end
   endfunction

   task automatic issue(input logic o, input logic s, input logic d,
                        input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      op = o; sgn = s; dword = d; rs = a; rt = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic issue_exp(input logic o, input logic s, input logic d,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] eh, input logic [63:0] el);
      exp_t e;
      e.ehi = eh; e.elo = el; e.lat = lat_of(o, d);
      sb.push_back(e);
      issue(o, s, d, a, b);
   endtask

   // Bounded wait for done, then pop and compare latency, HI, LO, pulse width
   task automatic wait_result(input string tag);
      exp_t e;
      int   k = 0;
      while (done !== 1'b1 && k < 300) begin
         @(posedge clk);
         #1 k++;
      end
      e = sb.pop_front();
      check({tag, "_lat"}, 64'(k), 64'(e.lat));
      check({tag, "_hi"}, hi, e.ehi);
      check({tag, "_lo"}, lo, e.elo);
      cur_hi = e.ehi; cur_lo = e.elo;
      @(posedge clk);
      #1;
      check({tag, "_done_once"}, 64'(done), 64'd0);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] a, b, eh, el;
      int          ndone;
      rst = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; dword = 1'b0;
      flush = 1'b0; wrhi = 1'b0; wrlo = 1'b0; rs = '0; rt = '0; wrdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hi", hi, 64'd0);
      check("reset_lo", lo, 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);

      // MULT -1 * 7
      issue_exp(1'b0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd7,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9);
      check("mult_busy_e0", 64'(busy), 64'd1);
      wait_result("mult");

      // DDIVU 100 / 7
      issue_exp(1'b1, 1'b0, 1'b1, 64'd100, 64'd7, 64'd2, 64'd14);
      wait_result("ddivu");

      // DIV -7 / 2
      issue_exp(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD);
      wait_result("div_neg");

      // DIV -5 / 0
      issue_exp(1'b1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFB, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFB, 64'd1);
      wait_result("div_by0_s");

      // DIVU 5 / 0
      issue_exp(1'b1, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_result("divu_by0");

      // DIV MININT / -1
      issue_exp(1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                64'd0, 64'hFFFF_FFFF_8000_0000);
      wait_result("div_ovf");

      // All eight op/sign/width combinations on random operands
      for (int i = 0; i < 8; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (i[0] && (b[31:0] == 32'd0 || b[31:0] == 32'hFFFF_FFFF)) b[31:0] = 32'd3;
         model(i[0], i[1], i[2], a, b, eh, el);
         issue_exp(i[0], i[1], i[2], a, b, eh, el);
         wait_result($sformatf("rand%0d", i));
      end

      // MTHI then MTLO in idle
      @(negedge clk);
      wrhi = 1'b1; wrdata = 64'h1234_5678_9ABC_DEF0;
      @(posedge clk);
      #1 wrhi = 1'b0;
      check("mthi", hi, 64'h1234_5678_9ABC_DEF0);
      check("mthi_lo_kept", lo, cur_lo);
      cur_hi = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
      wrlo = 1'b1; wrdata = 64'hCAFE_0000_0000_BEEF;
      @(posedge clk);
      #1 wrlo = 1'b0;
      check("mtlo", lo, 64'hCAFE_0000_0000_BEEF);
      cur_lo = 64'hCAFE_0000_0000_BEEF;

      // DMULTU flushed at cycle 10
      issue(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      ndone = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1 if (done === 1'b1) ndone++;
      end
      check("flush_no_done", 64'(ndone), 64'd0);
      check("flush_hi", hi, cur_hi);
      check("flush_lo", lo, cur_lo);

      // start together with flush is ignored
      @(negedge clk);
      op = 1'b0; sgn = 1'b0; dword = 1'b0; rs = 64'd9; rt = 64'd9;
      start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      check("start_flush_busy", 64'(busy), 64'd0);

      // start while busy: only the second operation's result appears
      issue(1'b0, 1'b0, 1'b1, 64'd1000, 64'd1000);
      repeat (5) @(posedge clk);
      #1;
      check("restart_hi_hold", hi, cur_hi);
      check("restart_lo_hold", lo, cur_lo);
      issue_exp(1'b1, 1'b0, 1'b1, 64'd100, 64'd7, 64'd2, 64'd14);
      wait_result("restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit owning the HI/LO registers. Sits downstream of instruction decode and register fetch, and executes every instruction the decoder marks with the long-ALU flag: MULT, MULTU, DMULT, DMULTU, DIV, DIVU, DDIV, DDIVU. The pipeline issues an operation with a one-cycle `start` pulse, then carries on. MFHI/MFLO and any new mul/div stall in the pipeline while `busy` is high.

## Interface
Parameters: none.

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  issue operation (single-cycle pulse)
- op  in  1  0 = multiply, 1 = divide
- sgn  in  1  signed operands
- dword  in  1  64-bit operation; when 0, only operand bits [31:0] are used
- rs  in  64  multiplicand / dividend
- rt  in  64  multiplier / divisor
- flush  in  1  exception flush; aborts the in-flight operation
- wrhi  in  1  MTHI write
- wrlo  in  1  MTLO write
- wrdata  in  64  MTHI/MTLO data
- hi  out  64  HI register
- lo  out  64  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse on the edge where HI/LO take a result

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- State machine:
  - IDLE → RUN on `start`; operands, op, sgn and dword are latched and the iteration counter is cleared.
  - RUN → FIX after the last iteration.
  - FIX → IDLE; sign correction is applied, then HI/LO are written and `done` is pulsed.
- Iteration count: word ops 32, dword ops 64, one bit per cycle.
  - Multiply: radix-2 shift-add on operand magnitudes.
  - Divide: restoring division on operand magnitudes.
- Signed ops use magnitudes; FIX negates:
  - the product when the operand signs differ;
  - the quotient when the operand signs differ;
  - the remainder when the dividend is negative.
- Word results:
  - Multiply: `lo` = sext(p[31:0]), `hi` = sext(p[63:32]).
  - Divide: `lo` = sext(q32), `hi` = sext(r32).
- Dword results:
  - Multiply: 128-bit product; `hi` = p[127:64], `lo` = p[63:0].
  - Divide: `lo` = q, `hi` = r.
- Divide by zero:
  - `hi` = dividend (sign-extended from bit 31 for word ops).
  - Unsigned: `lo` = all ones.
  - Signed: `lo` = 1 if the dividend is negative, else all ones (−1).
- Signed overflow (MININT / −1): `lo` = MININT (sign-extended for word ops), `hi` = 0.
- `start` while `busy`: the current operation is discarded and the new one begins. HI/LO stay unchanged.
- `flush`: returns to IDLE and drops `busy` on the next edge. HI/LO are unchanged and `done` does not pulse.
  - `flush` and `start` in the same cycle: `flush` wins and `start` is ignored.
- `wrhi`/`wrlo`: the register is written on the next edge.
  - If asserted while `busy`, the in-flight operation is also aborted, as for `flush`.
  - If asserted in the same cycle as the FIX-edge result, the MTHI/MTLO data wins for the register it targets.
  - If asserted in the same cycle as `start`, the write applies and the start is also accepted.

## Timing
- `start` is sampled at edge E0. `busy` is 1 from E0 through edge E0+N and is 0 in the cycle after.
- Latency:
  - Word ops: N = 33 (32 RUN cycles + 1 FIX).
  - Dword ops: N = 65.
- `hi`/`lo` update at edge E0+N; `done` is high for exactly the cycle following E0+N.
- `hi`/`lo` hold their old values throughout the operation. Reading them while `busy` is a pipeline hazard that the pipeline's stall prevents.
- Outputs are registered; there is no combinational path from any input to `hi`, `lo` or `busy`.

## Configuration
- `MULDIV_FASTMUL_EN` defined:
  - Multiply is performed in one cycle with the synthesis `*` operator on latched magnitudes, followed by FIX; N = 2 for both word and dword.
  - Divide is unchanged.
- Undefined: multiply is iterative, as described above.
- The result values are identical in both configurations; only latency differs.

## Test plan
- Reset, then idle → `hi`=`lo`=0 and `busy`=0.
- MULT with rs=0xFFFFFFFF (−1), rt=7, sgn=1 → after 33 cycles: `lo`=0xFFFFFFFFFFFFFFF9, `hi`=0xFFFFFFFFFFFFFFFF, `done` pulses once. With `MULDIV_FASTMUL_EN`, the same values appear after 2 cycles.
- DDIVU with rs=100, rt=7 → after 65 cycles: `lo`=14, `hi`=2. DIV with rs=−7, rt=2 → `lo`=−3, `hi`=−1.
- DIV with rs=−5, rt=0 → `lo`=1, `hi`=0xFFFFFFFFFFFFFFFB. DIVU with rs=5, rt=0 → `lo`=all ones, `hi`=5.
- DIV with rs=0x80000000, rt=−1 → `lo`=0xFFFFFFFF80000000, `hi`=0.
- DMULTU started, `flush` at cycle 10 → `busy` drops the next cycle, HI/LO unchanged, no `done`. Then `start` together with `flush` → ignored. Then `start` while `busy` → only the second result appears, at its own E0+N.
